// File: rtl/cbda8_reload.sv
// cbda8_reload -- cascadable 8-bit down counter with reload register.
//
// Ports:
//   CLK        rising-edge clock
//   CDN        asynchronous active-low reset (released synchronously by the
//              surrounding reset logic)
//   D0..D7     parallel load data (D0 = LSB)
//   LD         synchronous load of D into count and reload register;
//              enters RUN from any state; overrides counting
//   EN         count enable
//   BAI        borrow-in from the less-significant stage (tie 1 on LS stage)
//   ARL        at underflow: 1 = reload from R, 0 = wrap to 8'hFF
//   OS         at underflow: 1 = halt (one-shot), 0 = keep running
//   Q0..Q7     current count (Q0 = LSB)
//   BAO        combinational borrow-out to the next stage's BAI
//   TC         registered one-cycle terminal-count pulse per underflow
//   RUN        registered, high while the FSM is in the RUN state
module cbda8_reload (
  input  logic CLK,
  input  logic CDN,
  input  logic D0,
  input  logic D1,
  input  logic D2,
  input  logic D3,
  input  logic D4,
  input  logic D5,
  input  logic D6,
  input  logic D7,
  input  logic LD,
  input  logic EN,
  input  logic BAI,
  input  logic ARL,
  input  logic OS,
  output logic Q0,
  output logic Q1,
  output logic Q2,
  output logic Q3,
  output logic Q4,
  output logic Q5,
  output logic Q6,
  output logic Q7,
  output logic BAO,
  output logic TC,
  output logic RUN
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_q;
  logic [7:0] r_r;
  logic       r_tc;
  logic       r_run;

  logic [7:0] w_d;
  logic [7:0] w_q_nxt;
  logic [7:0] w_r_nxt;
  logic       w_tc_nxt;
  logic       w_ce;
  logic       w_uf;

  assign w_d  = {D7, D6, D5, D4, D3, D2, D1, D0};
  assign w_ce = BAI & EN & (r_state == S_RUN);
  // Underflow doubles as the borrow-out: the whole cascade resolves in one
  // cycle because every stage's BAO is a pure AND of its own state and BAI.
  assign w_uf = w_ce & (r_q == 8'h00);

  // ARL and OS are only consulted inside the underflow branch, so changing
  // them at any other time has no effect.
  always_comb begin
    w_state_nxt = r_state;
    w_q_nxt     = r_q;
    w_r_nxt     = r_r;
    w_tc_nxt    = 1'b0;
    if (LD) begin
      w_q_nxt     = w_d;
      w_r_nxt     = w_d;
      w_state_nxt = S_RUN;
    end else if (w_ce) begin
      if (r_q == 8'h00) begin
        w_q_nxt  = ARL ? r_r : 8'hFF;
        w_tc_nxt = 1'b1;
        if (OS) begin
          w_state_nxt = S_HALT;
        end
      end else begin
        w_q_nxt = r_q - 8'd1;
      end
    end
  end

  // RUN comes from its own flop, loaded with the decoded next state, so the
  // output never carries decode glitches from the state encoding.
  always_ff @(posedge CLK or negedge CDN) begin
    if (!CDN) begin
      r_state <= S_IDLE;
      r_q     <= 8'h00;
      r_r     <= 8'h00;
      r_tc    <= 1'b0;
      r_run   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_q     <= w_q_nxt;
      r_r     <= w_r_nxt;
      r_tc    <= w_tc_nxt;
      r_run   <= (w_state_nxt == S_RUN);
    end
  end

  assign {Q7, Q6, Q5, Q4, Q3, Q2, Q1, Q0} = r_q;
  assign BAO = w_uf;
  assign TC  = r_tc;
  assign RUN = r_run;

endmodule

// File: tb/tb_cbda8_reload.sv
// Directed bench for cbda8_reload: a single stage (u_ls) plus a second
// stage (u_ms) cascaded on u_ls's borrow-out for the 16-bit case.
module tb_cbda8_reload;

  logic       CLK;
  logic       CDN;
  logic [7:0] d;
  logic       ld, en, bai, arl, os;
  logic       ms_ld, ms_en;
  logic [7:0] q_ls, q_ms;
  logic       bao_ls, bao_ms, tc_ls, tc_ms, run_ls, run_ms;

  int vectors;
  int miscompares;

  cbda8_reload u_ls (
    .CLK(CLK), .CDN(CDN),
    .D0(d[0]), .D1(d[1]), .D2(d[2]), .D3(d[3]),
    .D4(d[4]), .D5(d[5]), .D6(d[6]), .D7(d[7]),
    .LD(ld), .EN(en), .BAI(bai), .ARL(arl), .OS(os),
    .Q0(q_ls[0]), .Q1(q_ls[1]), .Q2(q_ls[2]), .Q3(q_ls[3]),
    .Q4(q_ls[4]), .Q5(q_ls[5]), .Q6(q_ls[6]), .Q7(q_ls[7]),
    .BAO(bao_ls), .TC(tc_ls), .RUN(run_ls)
  );

  cbda8_reload u_ms (
    .CLK(CLK), .CDN(CDN),
    .D0(d[0]), .D1(d[1]), .D2(d[2]), .D3(d[3]),
    .D4(d[4]), .D5(d[5]), .D6(d[6]), .D7(d[7]),
    .LD(ms_ld), .EN(ms_en), .BAI(bao_ls), .ARL(arl), .OS(os),
    .Q0(q_ms[0]), .Q1(q_ms[1]), .Q2(q_ms[2]), .Q3(q_ms[3]),
    .Q4(q_ms[4]), .Q5(q_ms[5]), .Q6(q_ms[6]), .Q7(q_ms[7]),
    .BAO(bao_ms), .TC(tc_ms), .RUN(run_ms)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic [7:0] exp_q1 [8];
    logic       exp_tc1 [8];
    exp_q1  = '{8'h02, 8'h01, 8'h00, 8'h03, 8'h02, 8'h01, 8'h00, 8'h03};
    exp_tc1 = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vectors = 0;
    miscompares = 0;
    CDN = 1'b0; d = 8'h00; ld = 1'b0; en = 1'b0; bai = 1'b0;
    arl = 1'b0; os = 1'b0; ms_ld = 1'b0; ms_en = 1'b0;

    // Reset state, before any clock edge
    #3;
    chk("rst_q", q_ls, 8'h00);
    chk("rst_tc", tc_ls, 1'b0);
    chk("rst_run", run_ls, 1'b0);
    chk("rst_bao", bao_ls, 1'b0);
    repeat (2) @(negedge CLK);
    CDN = 1'b1;

    // Auto-reload count 3,2,1,0,3,...
    d = 8'h03; arl = 1'b1; os = 1'b0; en = 1'b1; bai = 1'b1; ld = 1'b1;
    tick();
    ld = 1'b0;
    chk("t1_load_q", q_ls, 8'h03);
    chk("t1_load_run", run_ls, 1'b1);
    chk("t1_load_bao", bao_ls, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t1_q", q_ls, exp_q1[i]);
      chk("t1_tc", tc_ls, exp_tc1[i]);
      chk("t1_bao", bao_ls, (exp_q1[i] == 8'h00));
    end

    // One-shot with wrap to FF, then HALT ignores EN/BAI
    d = 8'h02; arl = 1'b0; os = 1'b1; ld = 1'b1;
    tick();
    ld = 1'b0;
    chk("t2_load_q", q_ls, 8'h02);
    tick(); chk("t2_q1", q_ls, 8'h01);
    tick(); chk("t2_q0", q_ls, 8'h00); chk("t2_bao0", bao_ls, 1'b1);
    tick();
    chk("t2_qff", q_ls, 8'hFF);
    chk("t2_tc", tc_ls, 1'b1);
    chk("t2_run", run_ls, 1'b0);
    chk("t2_bao_halt", bao_ls, 1'b0);
    tick();
    chk("t2_hold_q", q_ls, 8'hFF);
    chk("t2_hold_tc", tc_ls, 1'b0);
    tick();
    chk("t2_hold_q2", q_ls, 8'hFF);
    chk("t2_hold_run", run_ls, 1'b0);

    // LD on the same edge as an underflow
    d = 8'h01; arl = 1'b1; os = 1'b0; ld = 1'b1;
    tick();
    ld = 1'b0;
    tick();
    chk("t3_q0", q_ls, 8'h00);
    chk("t3_bao", bao_ls, 1'b1);
    d = 8'h10; ld = 1'b1;
    tick();
    ld = 1'b0;
    chk("t3_q", q_ls, 8'h10);
    chk("t3_tc", tc_ls, 1'b0);
    chk("t3_run", run_ls, 1'b1);

    // EN gap holds the count without TC
    d = 8'h05; ld = 1'b1;
    tick();
    ld = 1'b0;
    chk("t5_load", q_ls, 8'h05);
    tick(); chk("t5_q4", q_ls, 8'h04);
    en = 1'b0;
    tick(); chk("t5_hold1", q_ls, 8'h04); chk("t5_tc1", tc_ls, 1'b0);
    tick(); chk("t5_hold2", q_ls, 8'h04); chk("t5_bao", bao_ls, 1'b0);
    en = 1'b1;
    tick(); chk("t5_q3", q_ls, 8'h03); chk("t5_tc2", tc_ls, 1'b0);
    tick(); chk("t5_q2", q_ls, 8'h02);

    // Asynchronous reset in the middle of a TC pulse
    tick(); tick();
    chk("t4_q0", q_ls, 8'h00);
    tick();
    chk("t4_reload", q_ls, 8'h05);
    chk("t4_tc_pre", tc_ls, 1'b1);
    #2;
    CDN = 1'b0;
    #1;
    chk("t4_rst_q", q_ls, 8'h00);
    chk("t4_rst_tc", tc_ls, 1'b0);
    chk("t4_rst_run", run_ls, 1'b0);
    chk("t4_rst_bao", bao_ls, 1'b0);
    @(negedge CLK);
    CDN = 1'b1;
    tick();
    chk("t4_post_q", q_ls, 8'h00);
    chk("t4_post_run", run_ls, 1'b0);
    tick();
    chk("t4_post_q2", q_ls, 8'h00);
    chk("t4_post_bao", bao_ls, 1'b0);

    // Two stages cascaded as a 16-bit counter
    d = 8'h00; arl = 1'b0; os = 1'b0; bai = 1'b1; en = 1'b1; ms_en = 1'b1;
    ld = 1'b1; ms_ld = 1'b1;
    tick();
    ld = 1'b0; ms_ld = 1'b0;
    chk("t6_0000", {q_ms, q_ls}, 16'h0000);
    chk("t6_bao_ls", bao_ls, 1'b1);
    tick();
    chk("t6_ffff", {q_ms, q_ls}, 16'hFFFF);
    chk("t6_tc_ms", tc_ms, 1'b1);
    chk("t6_bao_ls_off", bao_ls, 1'b0);
    tick();
    chk("t6_fffe", {q_ms, q_ls}, 16'hFFFE);
    chk("t6_tc_ms_off", tc_ms, 1'b0);
    tick();
    chk("t6_fffd", {q_ms, q_ls}, 16'hFFFD);
    chk("t6_bao_ms", bao_ms, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cbda8_reload.md
CBDA8_RELOAD -- requirements
Module: cbda8_reload

Interface
REQ-001 The block SHALL have port CLK, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port CDN, input, 1 bit: asynchronous, active-low reset; takes effect immediately on assertion; released synchronously to CLK.
REQ-003 The block SHALL have ports D0..D7, inputs, 1 bit each: parallel load data, D0 = LSB.
REQ-004 The block SHALL have port LD, input, 1 bit: synchronous load of D into the count and the reload register.
REQ-005 The block SHALL have port EN, input, 1 bit: count enable.
REQ-006 The block SHALL have port BAI, input, 1 bit: borrow-in from the less-significant stage; tie to 1 on the LS stage.
REQ-007 The block SHALL have port ARL, input, 1 bit: 1 = reload from R at underflow, 0 = wrap to 8'hFF.
REQ-008 The block SHALL have port OS, input, 1 bit: 1 = one-shot, halt after the first underflow.
REQ-009 The block SHALL have ports Q0..Q7, outputs, 1 bit each: current count, Q0 = LSB.
REQ-010 The block SHALL have port BAO, output, 1 bit: combinational borrow-out to the next stage's BAI.
REQ-011 The block SHALL have port TC, output, 1 bit: registered terminal-count pulse.
REQ-012 The block SHALL have port RUN, output, 1 bit: high while the FSM is in state RUN.

Function
REQ-013 The block SHALL hold internal registers Q[7:0] (count), R[7:0] (reload value), TC, and a 3-state FSM with states IDLE, RUN and HALT.
REQ-014 The block SHALL define the count event CE = BAI & EN & (state == RUN).
REQ-015 The block SHALL give LD priority over CE: on LD=1, Q <= D and R <= D, state <= RUN from any state, and TC <= 0, regardless of CE or Q.
REQ-016 In RUN with LD=0, CE=1 and Q != 0, the block SHALL set Q <= Q-1 and TC <= 0.
REQ-017 In RUN with LD=0, CE=1 and Q == 0 (underflow), the block SHALL set Q <= R if ARL=1 or Q <= 8'hFF if ARL=0, and SHALL set TC <= 1.
REQ-018 On an underflow with OS=1, the block SHALL move to state HALT; with OS=0 it SHALL stay in RUN.
REQ-019 With CE=0 and LD=0, the block SHALL hold Q, R and state, and SHALL set TC <= 0; TC SHALL therefore be high for exactly one cycle per underflow.
REQ-020 In IDLE and HALT, the block SHALL ignore EN and BAI; only LD SHALL leave these states, going to RUN.
REQ-021 The block SHALL drive BAO = BAI & EN & (state == RUN) & (Q == 0), combinationally with no registers, so that N cascaded stages form an N*8-bit down counter in one cycle.
REQ-022 The block SHALL drive RUN = (state == RUN), registered with no decode glitches.
REQ-023 The block SHALL use modulo-256 arithmetic with no saturation.
REQ-024 After LD with D=0, the block SHALL treat the first CE as an underflow.
REQ-025 In HALT, the block SHALL hold Q at its post-underflow value (R or FF).
REQ-026 The block SHALL sample ARL and OS only on the underflow cycle; changing them at any other time SHALL have no effect.

Reset
REQ-027 While CDN=0, the block SHALL hold Q=8'h00, R=8'h00, TC=0, state=IDLE, RUN=0 and BAO=0, asynchronously and independent of CLK.
REQ-028 When CDN is asserted mid-count or mid-TC-pulse, the block SHALL abort immediately with no residual TC.
REQ-029 After CDN is released, the block SHALL make the first state change only on a CLK edge with LD=1.

Verification
REQ-030 The bench SHALL cover: reset, then LD with D=8'h03, ARL=1, OS=0, EN=BAI=1 -> Q sequence 3,2,1,0,3,2,..., TC high exactly on the cycle after each Q=0, and BAO high only while Q=0.
REQ-031 The bench SHALL cover: LD with D=8'h02, ARL=0, OS=1, count -> Q sequence 2,1,0,FF, then HALT; RUN=0, Q stays FF, one TC pulse, and further EN/BAI are ignored until LD.
REQ-032 The bench SHALL cover: LD asserted on the same edge as an underflow (Q=0, CE=1) with D=8'h10 -> Q=10, TC=0, RUN=1.
REQ-033 The bench SHALL cover: two stages cascaded (LS BAI=1, MS BAI=LS BAO), both loaded with 8'h00, ARL=0 -> 16-bit sequence 0000, FFFF, FFFE; the MS stage decrements only when LS Q=0.
REQ-034 The bench SHALL cover: CDN pulsed low asynchronously between edges mid-count -> Q=00 and RUN=0 immediately; EN=1 without LD leaves Q=00 after release.
REQ-035 The bench SHALL cover: EN toggled 1,0,1 during RUN with D=8'h05 -> Q holds while EN=0, and no TC is produced.
